// File: rtl/axi_stream_input.sv
// AXI4-Stream slave: packs `groups` elements per SRAM word and writes the words from base_addr upward.
// Optional AXIS_IN_OVERFLOW_CHECK_EN stops writing past the top SRAM address and raises overflow.
//
// state | meaning
// IDLE  | waiting for start_input; config sampled on arm
// RECV  | accepting beats, packing lanes, writing completed words
// DONE  | tlast committed; waits for start_input to drop before re-arming
module axi_stream_input #(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 8,
  parameter int MAX_GROUPS         = 8,
  parameter int NUM_CHANNELS_WIDTH = $clog2(64+1),
  localparam int SRAM_WIDTH        = DATA_WIDTH*MAX_GROUPS
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
  input  logic                          start_input,
  input  logic [3:0]                    groups,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  output logic                          sram_in_en,
  output logic                          sram_in_we,
  output logic [ADDR_WIDTH-1:0]         sram_in_addr,
  output logic [SRAM_WIDTH-1:0]         sram_in_data,
  output logic [ADDR_WIDTH-1:0]         in_size,
  output logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
  output logic                          input_done,
  output logic                          overflow
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t                  state;
  logic [3:0]              groups_reg;
  logic [3:0]              groups_eff;
  logic [3:0]              lane_idx;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [SRAM_WIDTH-1:0]   pack_reg;
  logic [SRAM_WIDTH-1:0]   pack_next;
  logic                    first_beat;
  logic                    accept;
  logic                    word_done;
  logic                    write_ok;

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign word_done  = accept && (s_axis_tlast || (lane_idx == groups_reg - 4'd1));
  assign sram_in_we = sram_in_en;

  always_comb begin
    groups_eff = groups;
    if (groups == 4'd0)
      groups_eff = 4'd1;
    else if (groups > 4'(MAX_GROUPS))
      groups_eff = 4'(MAX_GROUPS);
  end

  // Current beat merged into its lane; the completing beat must be part of the written word.
  always_comb begin
    pack_next = pack_reg;
    for (int k = 0; k < MAX_GROUPS; k++)
      if (lane_idx == 4'(k))
        pack_next[k*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
  end

`ifdef AXIS_IN_OVERFLOW_CHECK_EN
  logic addr_exhausted;
  logic overflow_q;

  assign write_ok = !addr_exhausted;
  assign overflow = overflow_q;

  // The top address is still written; only words completing after it are dropped.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      addr_exhausted <= 1'b0;
      overflow_q     <= 1'b0;
    end else if (state == IDLE && start_input) begin
      addr_exhausted <= 1'b0;
      overflow_q     <= 1'b0;
    end else if (word_done) begin
      if (addr_exhausted)
        overflow_q <= 1'b1;
      else if (&word_addr)
        addr_exhausted <= 1'b1;
    end
  end
`else
  assign write_ok = 1'b1;
  assign overflow = 1'b0;
`endif

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state         <= IDLE;
      groups_reg    <= 4'd0;
      lane_idx      <= 4'd0;
      word_addr     <= '0;
      pack_reg      <= '0;
      first_beat    <= 1'b0;
      s_axis_tready <= 1'b0;
      sram_in_en    <= 1'b0;
      sram_in_addr  <= '0;
      sram_in_data  <= '0;
      in_size       <= '0;
      num_channels  <= '0;
      input_done    <= 1'b0;
    end else begin
      sram_in_en <= 1'b0;
      input_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_input) begin
            state         <= RECV;
            s_axis_tready <= 1'b1;
            groups_reg    <= groups_eff;
            word_addr     <= base_addr;
            lane_idx      <= 4'd0;
            pack_reg      <= '0;
            in_size       <= '0;
            first_beat    <= 1'b1;
          end
        end
        RECV: begin
          if (accept) begin
            in_size    <= in_size + 1'b1;
            first_beat <= 1'b0;
            if (first_beat)
              num_channels <= s_axis_tuser;
            if (word_done) begin
              sram_in_en   <= write_ok;
              sram_in_addr <= word_addr;
              sram_in_data <= pack_next;
              word_addr    <= word_addr + 1'b1;
              pack_reg     <= '0;
              lane_idx     <= 4'd0;
            end else begin
              pack_reg <= pack_next;
              lane_idx <= lane_idx + 4'd1;
            end
            if (s_axis_tlast) begin
              state         <= DONE;
              s_axis_tready <= 1'b0;
              input_done    <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!start_input)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_input.sv
// Bench for axi_stream_input: table of transfers, packing model feeding a write scoreboard,
// plus hand-written reset-abort and held-start sequences.
module tb_axi_stream_input;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MG = 8;
  localparam int SW = DW*MG;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [CW-1:0] s_axis_tuser;
  logic          start_input;
  logic [3:0]    groups;
  logic [AW-1:0] base_addr;
  logic          sram_in_en;
  logic          sram_in_we;
  logic [AW-1:0] sram_in_addr;
  logic [SW-1:0] sram_in_data;
  logic [AW-1:0] in_size;
  logic [CW-1:0] num_channels;
  logic          input_done;
  logic          overflow;

  always #5 clk = ~clk;

  axi_stream_input dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .start_input   (start_input),
    .groups        (groups),
    .base_addr     (base_addr),
    .sram_in_en    (sram_in_en),
    .sram_in_we    (sram_in_we),
    .sram_in_addr  (sram_in_addr),
    .sram_in_data  (sram_in_data),
    .in_size       (in_size),
    .num_channels  (num_channels),
    .input_done    (input_done),
    .overflow      (overflow)
  );

  typedef struct {
    logic [3:0]    grp;
    logic [AW-1:0] base;
    int            nbeats;
    logic [CW-1:0] tuser;
    bit            gaps;
    bit            hold;
    logic [7:0]    first_val;
    int            exp_words;
    logic          exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  vec_t          tbl[7];
  int            vectors = 0;
  int            miscompares = 0;
  int            done_cnt = 0;
  int            write_cnt = 0;
  logic [AW-1:0] size_at_done;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (sram_in_en === 1'b1) begin
      write_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", 128'(sram_in_addr), 128'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("write_addr", 128'(sram_in_addr), 128'(e.addr));
        chk("write_data", 128'(sram_in_data), 128'(e.data));
        chk("write_we", 128'(sram_in_we), 128'd1);
      end
    end
    if (input_done === 1'b1) begin
      done_cnt++;
      size_at_done = in_size;
      chk("tready_low_at_done", 128'(s_axis_tready), 128'd0);
      chk("writes_pending_at_done", 128'(sb.size()), 128'd0);
    end
  end

  task automatic run_xfer(input vec_t v);
    logic [SW-1:0] pack;
    logic [AW-1:0] addr;
    logic [7:0]    d;
    int            lane;
    int            g;
    bit            exhausted;
    int            done0;
    int            wc0;
    done0 = done_cnt;
    wc0   = write_cnt;
    g     = (v.grp == 4'd0) ? 1 : ((v.grp > 4'd8) ? 8 : int'(v.grp));
    @(negedge clk);
    start_input = 1'b1;
    groups      = v.grp;
    base_addr   = v.base;
    @(negedge clk);
    chk("tready_after_arm", 128'(s_axis_tready), 128'd1);
    pack = '0; lane = 0; addr = v.base; exhausted = 1'b0;
    for (int i = 0; i < v.nbeats; i++) begin
      if (v.gaps && i > 0) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      d = v.first_val + 8'(i);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = (i == v.nbeats-1);
      s_axis_tuser  = (i == 0) ? v.tuser : 7'h55;
      pack[lane*DW +: DW] = d;
      lane++;
      if (lane == g || i == v.nbeats-1) begin
        if (!exhausted) sb.push_back({addr, pack});
`ifdef AXIS_IN_OVERFLOW_CHECK_EN
        if (&addr) exhausted = 1'b1;
`endif
        addr = addr + 1'b1;
        pack = '0;
        lane = 0;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!v.hold) start_input = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_pulses", 128'(done_cnt - done0), 128'd1);
    chk("in_size_at_done", 128'(size_at_done), 128'(v.nbeats));
    chk("num_channels", 128'(num_channels), 128'(v.tuser));
    chk("write_count", 128'(write_cnt - wc0), 128'(v.exp_words));
    chk("overflow", 128'(overflow), 128'(v.exp_ovf));
    if (v.hold) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'hAA;
      repeat (5) @(negedge clk);
      chk("held_start_tready", 128'(s_axis_tready), 128'd0);
      chk("held_start_no_rearm", 128'(write_cnt - wc0), 128'(v.exp_words));
      s_axis_tvalid = 1'b0;
      start_input   = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start_input = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; s_axis_tuser = '0; groups = 4'd4; base_addr = '0;

    tbl[0] = '{4'd4,  13'h0010, 8, 7'd3,  1'b0, 1'b0, 8'h01, 2, 1'b0};
    tbl[1] = '{4'd3,  13'h0040, 7, 7'd9,  1'b0, 1'b1, 8'h01, 3, 1'b0};
    tbl[2] = '{4'd1,  13'h0080, 5, 7'd12, 1'b1, 1'b0, 8'h01, 5, 1'b0};
    tbl[3] = '{4'd0,  13'h0100, 2, 7'd64, 1'b0, 1'b0, 8'h30, 2, 1'b0};
    tbl[4] = '{4'd12, 13'h0200, 10, 7'd1, 1'b0, 1'b0, 8'hF0, 2, 1'b0};
    tbl[5] = '{4'd8,  13'h0300, 8, 7'd7,  1'b0, 1'b0, 8'h81, 1, 1'b0};
`ifdef AXIS_IN_OVERFLOW_CHECK_EN
    tbl[6] = '{4'd1,  13'h1FFF, 3, 7'd5,  1'b0, 1'b0, 8'h11, 1, 1'b1};
`else
    tbl[6] = '{4'd1,  13'h1FFF, 3, 7'd5,  1'b0, 1'b0, 8'h11, 3, 1'b0};
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        128'({s_axis_tready, sram_in_en, sram_in_we, sram_in_addr, in_size, num_channels,
              input_done, overflow}), 128'd0);
    chk("reset_data", 128'(sram_in_data), 128'd0);

    for (int t = 0; t < 7; t++) run_xfer(tbl[t]);

    // Abort mid-word: two beats then reset; nothing may be written.
    @(negedge clk);
    start_input = 1'b1; groups = 4'd4; base_addr = 13'h0020;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'hE0 + 8'(i); s_axis_tlast = 1'b0;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    rst = 1'b1; start_input = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs",
        128'({s_axis_tready, sram_in_en, sram_in_addr, in_size, num_channels,
              input_done, overflow}), 128'd0);
    chk("abort_data", 128'(sram_in_data), 128'd0);
    run_xfer('{4'd4, 13'h0020, 4, 7'd2, 1'b0, 1'b0, 8'h41, 1, 1'b0});

    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
